muldiv_seq: RTL and testbench

- Iterative multiply/divide sequencer for the single-cycle MIPS datapath.
- Owns the HI/LO registers and executes MULT/MULTU/DIV/DIVU over multiple cycles.
- Drives a stall to the PC update logic whenever the datapath requests HI/LO or a new mul/div while an operation is in flight.
- Sits beside the ALU; operands come from regfile rdata1 (rs) and rdata2 (rt).

---
 rtl/muldiv_seq.sv | 170 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// Optional MULDIV_EARLY_TERM_EN: multiply early exit plus sticky div0_out.
module muldiv_seq #(
    parameter int W     = 32,
    parameter int CNT_W = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start_in,
    input  logic [1:0]   op_in,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic         mthi_in,
    input  logic         mtlo_in,
    input  logic         hilo_rd_in,
    output logic [W-1:0] hi_out,
    output logic [W-1:0] lo_out,
    output logic         busy_out,
    output logic         stall_out,
    output logic         div0_out
);
    localparam logic [1:0]       S_IDLE   = 2'd0;
    localparam logic [1:0]       S_RUN    = 2'd1;
    localparam logic [1:0]       S_FIX    = 2'd2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    logic [1:0]       r_state;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_opa;
    logic [W-1:0]     r_opb;
    logic [2*W-1:0]   r_acc;
    logic [W-1:0]     r_rem;
    logic [W-1:0]     r_hi;
    logic [W-1:0]     r_lo;

    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [W-1:0]     w_a_mag;
    logic [W-1:0]     w_b_mag;
    logic             w_dz;
    logic [W:0]       w_sum;
    logic [2*W-1:0]   w_acc_mul;
    logic [W:0]       w_shift;
    logic             w_ge;
    logic [W-1:0]     w_rem_next;
    logic             w_last;
    logic [2*W-1:0]   w_prod;
    logic [2*W-1:0]   w_prod_fix;
    logic [W-1:0]     w_quo;
    logic [W-1:0]     w_rmd;

    assign w_signed = ~op_in[0];
    assign w_a_neg  = w_signed & a_in[W-1];
    assign w_b_neg  = w_signed & b_in[W-1];
    assign w_a_mag  = w_a_neg ? -a_in : a_in;
    assign w_b_mag  = w_b_neg ? -b_in : b_in;
    assign w_dz     = op_in[1] & (b_in == '0);

    // Multiply: add multiplicand into the upper half, then shift the whole accumulator right.
    assign w_sum     = {1'b0, r_acc[2*W-1:W]} + (r_opb[0] ? {1'b0, r_opa} : '0);
    assign w_acc_mul = {w_sum, r_acc[W-1:1]};

    // Divide: restoring step; quotient bits shift into r_acc[W-1:0] as dividend bits leave.
    assign w_shift    = {r_rem, r_acc[W-1]};
    assign w_ge       = (w_shift >= {1'b0, r_opb});
    assign w_rem_next = w_ge ? W'(w_shift - {1'b0, r_opb}) : w_shift[W-1:0];

`ifdef MULDIV_EARLY_TERM_EN
    logic             r_div0;
    logic [CNT_W-1:0] w_shamt;

    // After k steps the accumulator holds product << (W-k); counter wraps to 0 after W steps.
    assign w_shamt  = -r_cnt;
    assign w_prod   = r_acc >> w_shamt;
    assign w_last   = (r_cnt == CNT_LAST) || (!r_is_div && (r_opb[W-1:1] == '0));
    assign div0_out = r_div0;
`else
    assign w_prod   = r_acc;
    assign w_last   = (r_cnt == CNT_LAST);
    assign div0_out = 1'b0;
`endif

    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo      = r_neg_q ? -r_acc[W-1:0] : r_acc[W-1:0];
    assign w_rmd      = r_neg_r ? -r_rem : r_rem;

    assign hi_out    = r_hi;
    assign lo_out    = r_lo;
    assign busy_out  = (r_state != S_IDLE);
    assign stall_out = busy_out & (start_in | hilo_rd_in | mthi_in | mtlo_in);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_cnt    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
`ifdef MULDIV_EARLY_TERM_EN
            r_div0   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_in) begin
                        r_is_div <= op_in[1];
                        r_cnt    <= '0;
                        r_rem    <= '0;
                        if (w_dz) begin
                            r_dz    <= 1'b1;
                            r_opa   <= a_in;
                            r_state <= S_FIX;
`ifdef MULDIV_EARLY_TERM_EN
                            r_div0  <= 1'b1;
`endif
                        end else begin
                            r_dz    <= 1'b0;
                            r_opa   <= w_a_mag;
                            r_opb   <= w_b_mag;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                            r_acc   <= op_in[1] ? {W'(0), w_a_mag} : '0;
                            r_state <= S_RUN;
                        end
                    end else begin
                        if (mthi_in) r_hi <= a_in;
                        if (mtlo_in) r_lo <= a_in;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_is_div) begin
                        r_rem <= w_rem_next;
                        r_acc <= {W'(0), r_acc[W-2:0], w_ge};
                    end else begin
                        r_acc <= w_acc_mul;
                        r_opb <= r_opb >> 1;
                    end
                    if (w_last) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_dz) begin
                        r_hi <= r_opa;
                        r_lo <= '1;
                    end else if (r_is_div) begin
                        r_hi <= w_rmd;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod_fix[2*W-1:W];
                        r_lo <= w_prod_fix[W-1:0];
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: results, latency, stall, mt writes and async reset.
// Latency / div0 expectations follow MULDIV_EARLY_TERM_EN when it is defined.
module tb_muldiv_seq;
    localparam int W        = 32;
    localparam int LAT_FULL = 33;
`ifdef MULDIV_EARLY_TERM_EN
    localparam int   LAT_SMALL = 4;
    localparam logic EXP_DZ    = 1'b1;
`else
    localparam int   LAT_SMALL = 33;
    localparam logic EXP_DZ    = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start_in = 1'b0;
    logic [1:0]   op_in = 2'b00;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         mthi_in = 1'b0;
    logic         mtlo_in = 1'b0;
    logic         hilo_rd_in = 1'b0;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;
    logic         busy_out;
    logic         stall_out;
    logic         div0_out;

    int checks = 0;
    int errors = 0;

    muldiv_seq #(.W(W), .CNT_W(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .start_in   (start_in),
        .op_in      (op_in),
        .a_in       (a_in),
        .b_in       (b_in),
        .mthi_in    (mthi_in),
        .mtlo_in    (mtlo_in),
        .hilo_rd_in (hilo_rd_in),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .busy_out   (busy_out),
        .stall_out  (stall_out),
        .div0_out   (div0_out)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Launch one operation and count the busy cycles seen at negedges.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int cyc);
        @(negedge clock);
        start_in = 1'b1; op_in = op; a_in = a; b_in = b;
        @(negedge clock);
        start_in = 1'b0;
        cyc = 0;
        while (busy_out && cyc < 100) begin
            cyc++;
            @(negedge clock);
        end
    endtask

    initial begin
        int n;
        int bad;

        // Reset state
        @(negedge clock);
        chk("rst_hi", hi_out, 32'h0);
        chk("rst_lo", lo_out, 32'h0);
        chk("rst_busy", {31'b0, busy_out}, 32'h0);
        chk("rst_stall", {31'b0, stall_out}, 32'h0);
        chk("rst_div0", {31'b0, div0_out}, 32'h0);
        reset = 1'b0;

        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
        chk("multu_max_lat", n, LAT_FULL);
        chk("multu_max_hi", hi_out, 32'hFFFFFFFE);
        chk("multu_max_lo", lo_out, 32'h00000001);

        run_op(2'b00, 32'hFFFFFFFD, 32'd7, n);
        chk("mult_neg_lat", n, LAT_SMALL);
        chk("mult_neg_hi", hi_out, 32'hFFFFFFFF);
        chk("mult_neg_lo", lo_out, 32'hFFFFFFEB);

        run_op(2'b10, 32'hFFFFFFF9, 32'd2, n);
        chk("div_neg_lat", n, LAT_FULL);
        chk("div_neg_lo", lo_out, 32'hFFFFFFFD);
        chk("div_neg_hi", hi_out, 32'hFFFFFFFF);

        run_op(2'b11, 32'h00001234, 32'h0, n);
        chk("divu0_lat", n, 1);
        chk("divu0_lo", lo_out, 32'hFFFFFFFF);
        chk("divu0_hi", hi_out, 32'h00001234);
        chk("divu0_flag", {31'b0, div0_out}, {31'b0, EXP_DZ});

        run_op(2'b00, 32'h80000000, 32'h80000000, n);
        chk("mult_min_hi", hi_out, 32'h40000000);
        chk("mult_min_lo", lo_out, 32'h00000000);

        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, n);
        chk("div_min_lo", lo_out, 32'h80000000);
        chk("div_min_hi", hi_out, 32'h00000000);
        chk("div0_sticky", {31'b0, div0_out}, {31'b0, EXP_DZ});

        // MTHI / MTLO in IDLE
        @(negedge clock);
        mthi_in = 1'b1; a_in = 32'hAAAA5555;
        @(negedge clock);
        mthi_in = 1'b0; mtlo_in = 1'b1; a_in = 32'h12345678;
        @(negedge clock);
        mtlo_in = 1'b0;
        chk("mthi", hi_out, 32'hAAAA5555);
        chk("mtlo", lo_out, 32'h12345678);

        // Start together with MTHI: start wins, HI untouched until FIX
        start_in = 1'b1; mthi_in = 1'b1; op_in = 2'b01; a_in = 32'd2; b_in = 32'd3;
        @(negedge clock);
        start_in = 1'b0; mthi_in = 1'b0;
        chk("start_mthi_busy", {31'b0, busy_out}, 32'h1);
        chk("start_mthi_hi_kept", hi_out, 32'hAAAA5555);
        n = 0;
        while (busy_out && n < 100) begin
            n++;
            @(negedge clock);
        end
        chk("start_mthi_hi", hi_out, 32'h0);
        chk("start_mthi_lo", lo_out, 32'd6);

        // MFHI/MFLO during an operation stalls until busy falls; LO not exposed early
        start_in = 1'b1; op_in = 2'b01; a_in = 32'd6; b_in = 32'd7;
        @(negedge clock);
        start_in = 1'b0; hilo_rd_in = 1'b1;
        n = 0; bad = 0;
        while (busy_out && n < 100) begin
            n++;
            if (stall_out !== 1'b1 || lo_out !== 32'd6) bad++;
            @(negedge clock);
        end
        chk("hilo_rd_stall_cycles", bad, 0);
        chk("hilo_rd_lat", n, LAT_SMALL);
        chk("hilo_rd_stall_off", {31'b0, stall_out}, 32'h0);
        chk("hilo_rd_lo", lo_out, 32'd42);
        chk("hilo_rd_hi", hi_out, 32'd0);
        hilo_rd_in = 1'b0;

        // Start while busy is held off and accepted once IDLE
        start_in = 1'b1; op_in = 2'b01; a_in = 32'd3; b_in = 32'd5;
        @(negedge clock);
        a_in = 32'd4; b_in = 32'd4;
        n = 0; bad = 0;
        while (busy_out && n < 100) begin
            n++;
            if (stall_out !== 1'b1) bad++;
            @(negedge clock);
        end
        chk("pend_stall_cycles", bad, 0);
        chk("pend_first_lo", lo_out, 32'd15);
        chk("pend_stall_off", {31'b0, stall_out}, 32'h0);
        @(negedge clock);
        start_in = 1'b0;
        chk("pend_accept_busy", {31'b0, busy_out}, 32'h1);
        n = 0;
        while (busy_out && n < 100) begin
            n++;
            @(negedge clock);
        end
        chk("pend_second_lo", lo_out, 32'd16);

        // Asynchronous reset in the middle of DIVU 100/7
        start_in = 1'b1; op_in = 2'b11; a_in = 32'd100; b_in = 32'd7;
        @(negedge clock);
        start_in = 1'b0;
        repeat (9) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", {31'b0, busy_out}, 32'h0);
        chk("arst_hi", hi_out, 32'h0);
        chk("arst_lo", lo_out, 32'h0);
        chk("arst_div0", {31'b0, div0_out}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("arst_stays_idle", {31'b0, busy_out}, 32'h0);

        run_op(2'b01, 32'd3, 32'd5, n);
        chk("post_rst_lat", n, LAT_SMALL);
        chk("post_rst_lo", lo_out, 32'd15);
        chk("post_rst_hi", hi_out, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
